spi_frame_ctrl: RTL and testbench

//  Frame-level controller downstream of the SPI slave byte shifter. Consumes received bytes,

---
 rtl/spi_frame_ctrl.sv | 160 ++++++++++++++++
 tb/tb_spi_frame_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_ctrl.sv
// Frame controller behind the SPI slave byte shifter: CMD[,DATA][,CRC] -> register bus.
// Optional feature macro: SPI_FRAME_CRC_EN (CRC byte check before committing writes).
module spi_frame_ctrl #(
    parameter int          ERR_W     = 8,
    parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_ss,
    input  logic [7:0]       rx_byte,
    input  logic             rx_strobe,
    input  logic [7:0]       crc_in,
    input  logic             tx_strobe,
    output logic [7:0]       tx_byte,
    output logic [6:0]       reg_addr,
    output logic [7:0]       reg_wdata,
    output logic             reg_we,
    output logic             reg_re,
    input  logic [7:0]       reg_rdata,
    output logic             frame_err,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_WDATA, S_RRESP, S_CRC, S_DONE
    } state_t;

    state_t     state, state_n;
    logic       we_n, re_n, err_n;
    logic       is_wr, sticky_err;
    logic       cap_pend, crc_pend, ovr;
    logic       rd_valid, rd_loaded;
    logic [7:0] rd_data;
    logic       cmd_hit, data_hit, crc_hit;

    // spi_ss high always beats a same-cycle rx_strobe
    assign cmd_hit  = (state == S_CMD)   && !spi_ss && rx_strobe;
    assign data_hit = (state == S_WDATA) && !spi_ss && rx_strobe;
    assign crc_hit  = (state == S_CRC)   && !spi_ss && rx_strobe && !crc_pend;

    always_comb begin
        state_n = state;
        we_n    = 1'b0;
        re_n    = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!spi_ss) state_n = S_CMD;
            end
            S_CMD: begin
                if (spi_ss) begin
                    state_n = S_IDLE;
                end else if (rx_strobe) begin
                    state_n = rx_byte[7] ? S_WDATA : S_RRESP;
                    re_n    = !rx_byte[7];
                end
            end
            S_WDATA: begin
                if (spi_ss) begin
                    state_n = S_IDLE;
                    err_n   = 1'b1;
                end else if (rx_strobe) begin
`ifdef SPI_FRAME_CRC_EN
                    state_n = S_CRC;
`else
                    state_n = S_DONE;
                    we_n    = 1'b1;
`endif
                end
            end
            S_RRESP: begin
                if (spi_ss) begin
                    state_n = S_IDLE;
                    err_n   = 1'b1;
`ifdef SPI_FRAME_CRC_EN
                end else if (cap_pend) begin
                    state_n = S_CRC;
`else
                end else if (rx_strobe && rd_loaded) begin
                    state_n = S_DONE;
`endif
                end
            end
            S_CRC: begin
                if (spi_ss) begin
                    state_n = S_IDLE;
                    err_n   = 1'b1;
                end else if (crc_pend) begin
                    state_n = S_DONE;
                    if (crc_in == 8'h00) we_n  = is_wr;
                    else                 err_n = 1'b1;
                end
            end
            S_DONE: begin
                if (spi_ss)                 state_n = S_IDLE;
                else if (rx_strobe && !ovr) err_n   = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            frame_err  <= 1'b0;
            err_cnt    <= '0;
            sticky_err <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            is_wr      <= 1'b0;
            cap_pend   <= 1'b0;
            crc_pend   <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            rd_loaded  <= 1'b0;
            ovr        <= 1'b0;
        end else begin
            state     <= state_n;
            reg_we    <= we_n;
            reg_re    <= re_n;
            frame_err <= err_n;
            if (err_n) begin
                sticky_err <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
            end else if (tx_strobe && state == S_CMD) begin
                sticky_err <= 1'b0;
            end
            if (cmd_hit) begin
                reg_addr <= rx_byte[6:0];
                is_wr    <= rx_byte[7];
            end
            if (data_hit) reg_wdata <= rx_byte;
            cap_pend <= reg_re && (state_n == S_RRESP);
            crc_pend <= crc_hit;
            // read data lands one clk after reg_re, held until the shifter loads it
            if (cap_pend && state == S_RRESP && !spi_ss) begin
                rd_data  <= reg_rdata;
                rd_valid <= 1'b1;
            end else if (tx_strobe && rd_valid) begin
                rd_valid  <= 1'b0;
                rd_loaded <= 1'b1;
            end
            if (err_n && state == S_DONE) ovr <= 1'b1;
            if (state_n == S_IDLE) begin
                rd_valid  <= 1'b0;
                rd_loaded <= 1'b0;
                ovr       <= 1'b0;
            end
        end
    end

    always_comb begin
        if (state == S_IDLE || state == S_CMD) tx_byte = {sticky_err, 7'b0};
        else if (rd_valid)                     tx_byte = rd_data;
        else                                   tx_byte = FILL_BYTE;
    end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Randomised frame-level bench for spi_frame_ctrl against a byte-list reference model.
// Builds with or without SPI_FRAME_CRC_EN.
module tb_spi_frame_ctrl;

    localparam int         ERR_W  = 8;
    localparam logic [7:0] FILL   = 8'hFF;
    localparam int         CNTMAX = (1 << ERR_W) - 1;
`ifdef SPI_FRAME_CRC_EN
    localparam bit CRC_ON = 1'b1;
    localparam int WE_LAT = 2;
`else
    localparam bit CRC_ON = 1'b0;
    localparam int WE_LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             spi_ss;
    logic [7:0]       rx_byte;
    logic             rx_strobe;
    logic [7:0]       crc_in;
    logic             tx_strobe;
    logic [7:0]       tx_byte;
    logic [6:0]       reg_addr;
    logic [7:0]       reg_wdata;
    logic             reg_we;
    logic             reg_re;
    logic [7:0]       reg_rdata;
    logic             frame_err;
    logic [ERR_W-1:0] err_cnt;

    spi_frame_ctrl #(.ERR_W(ERR_W), .FILL_BYTE(FILL)) dut (
        .clk(clk), .rst(rst), .spi_ss(spi_ss),
        .rx_byte(rx_byte), .rx_strobe(rx_strobe), .crc_in(crc_in),
        .tx_strobe(tx_strobe), .tx_byte(tx_byte),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
        .frame_err(frame_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int we_cnt = 0, re_cnt = 0, fe_cnt = 0;
    logic [6:0] we_addr;
    logic [7:0] we_data;

    always @(posedge clk) begin
        if (!rst) begin
            if (reg_we) begin
                we_cnt  <= we_cnt + 1;
                we_addr <= reg_addr;
                we_data <= reg_wdata;
            end
            if (reg_re)    re_cnt <= re_cnt + 1;
            if (frame_err) fe_cnt <= fe_cnt + 1;
        end
    end

    int         exp_errcnt = 0;
    bit         exp_sticky = 1'b0;
    logic [7:0] crc_run;
    logic [7:0] rd_val;
    logic [7:0] fb[$];

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte = b;
        rx_strobe = 1'b1;
        @(negedge clk);
        rx_strobe = 1'b0;
        crc_run = crc8(crc_run, b);
        crc_in = CRC_ON ? crc_run : 8'($urandom);
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_tx();
        @(negedge clk);
        tx_strobe = 1'b1;
        @(negedge clk);
        tx_strobe = 1'b0;
    endtask

    task automatic start_frame(input string nm);
        @(negedge clk);
        spi_ss = 1'b0;
        crc_run = 8'h00;
        repeat (2) @(negedge clk);
        n_chk++;
        if (tx_byte !== {exp_sticky, 7'h0}) begin
            n_fail++;
            $display("FAIL %s status: got %h want %h", nm, tx_byte, {exp_sticky, 7'h0});
        end
        exp_sticky = 1'b0;
        pulse_tx();
    endtask

    task automatic check_errcnt(input string nm);
        n_chk++;
        if (err_cnt !== ERR_W'(exp_errcnt)) begin
            n_fail++;
            $display("FAIL %s err_cnt: got %0d want %0d", nm, err_cnt, exp_errcnt);
        end
    endtask

    task automatic account_err(input int xerr);
        exp_errcnt = exp_errcnt + xerr;
        if (exp_errcnt > CNTMAX) exp_errcnt = CNTMAX;
        if (xerr > 0) exp_sticky = 1'b1;
    endtask

    // Send fb as one frame, then predict bus/error outcome from the byte list.
    task automatic run_frame(input string nm);
        int we0, re0, fe0, n, need, xerr;
        bit wr, good, xwe, xre;
        logic [7:0] c, miso;
        we0 = we_cnt; re0 = re_cnt; fe0 = fe_cnt;
        n = fb.size();
        wr = (n > 0) ? fb[0][7] : 1'b0;
        need = (wr && CRC_ON) ? 3 : 2;
        reg_rdata = rd_val;
        start_frame(nm);
        for (int k = 0; k < n; k++) begin
            send_byte(fb[k]);
            miso = (!wr && k == 0) ? rd_val : FILL;
            n_chk++;
            if (tx_byte !== miso) begin
                n_fail++;
                $display("FAIL %s miso%0d: got %h want %h", nm, k + 1, tx_byte, miso);
            end
            pulse_tx();
        end
        spi_ss = 1'b1;
        repeat (3) @(negedge clk);
        good = 1'b1;
        if (CRC_ON && n >= need) begin
            c = 8'h00;
            for (int k = 0; k < need; k++) c = crc8(c, fb[k]);
            good = (c == 8'h00);
        end
        xre = !wr && n >= 1;
        xwe = 1'b0;
        xerr = 0;
        if (n == 0) xerr = 0;
        else if (n < need) xerr = 1;
        else begin
            xwe = wr && good;
            xerr = (good ? 0 : 1) + (n > need ? 1 : 0);
        end
        account_err(xerr);
        n_chk++;
        if (we_cnt - we0 !== int'(xwe)) begin
            n_fail++;
            $display("FAIL %s we: got %0d want %0d", nm, we_cnt - we0, xwe);
        end
        n_chk++;
        if (re_cnt - re0 !== int'(xre)) begin
            n_fail++;
            $display("FAIL %s re: got %0d want %0d", nm, re_cnt - re0, xre);
        end
        n_chk++;
        if (fe_cnt - fe0 !== xerr) begin
            n_fail++;
            $display("FAIL %s frame_err: got %0d want %0d", nm, fe_cnt - fe0, xerr);
        end
        if (xwe) begin
            n_chk++;
            if (we_addr !== fb[0][6:0] || we_data !== fb[1]) begin
                n_fail++;
                $display("FAIL %s wr: got %h/%h want %h/%h", nm, we_addr, we_data, fb[0][6:0], fb[1]);
            end
        end
        check_errcnt(nm);
    endtask

    task automatic build(input bit wr, input int n, input logic [7:0] corrupt);
        logic [7:0] c;
        int need;
        fb.delete();
        fb.push_back({wr, 7'($urandom)});
        need = (wr && CRC_ON) ? 3 : 2;
        if (wr) fb.push_back(8'($urandom));
        if (CRC_ON) begin
            c = 8'h00;
            foreach (fb[i]) c = crc8(c, fb[i]);
            fb.push_back(c ^ corrupt);
        end else if (!wr) begin
            fb.push_back(8'($urandom));
        end
        while (fb.size() < n) fb.push_back(8'($urandom));
        while (fb.size() > n) void'(fb.pop_back());
        if (fb.size() != 0 && fb.size() > need + 1) $display("note: long frame");
    endtask

    task automatic test_reset();
        n_chk++;
        if ({tx_byte, reg_we, reg_re, frame_err} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset outs: got %h", {tx_byte, reg_we, reg_re, frame_err});
        end
        n_chk++;
        if ({reg_addr, reg_wdata} !== 15'h0) begin
            n_fail++;
            $display("FAIL reset bus: got %h", {reg_addr, reg_wdata});
        end
        check_errcnt("reset");
    endtask

    task automatic test_write();
        fb = '{8'h85, 8'h3C};
        if (CRC_ON) fb.push_back(crc8(crc8(8'h00, 8'h85), 8'h3C));
        rd_val = 8'h00;
        run_frame("write");
    endtask

    task automatic test_we_timing();
        logic [7:0] b;
        int fe0;
        fe0 = fe_cnt;
        start_frame("we_tim");
        send_byte(8'h85);
        b = 8'h3C;
        if (CRC_ON) begin
            send_byte(8'h3C);
            b = crc_run;
        end
        @(negedge clk);
        rx_byte = b;
        rx_strobe = 1'b1;
        for (int i = 1; i <= WE_LAT + 1; i++) begin
            @(negedge clk);
            if (i == 1) begin
                rx_strobe = 1'b0;
                crc_run = crc8(crc_run, b);
                crc_in = CRC_ON ? crc_run : 8'h5A;
            end
            n_chk++;
            if (reg_we !== (i == WE_LAT)) begin
                n_fail++;
                $display("FAIL we_tim clk%0d: got %b want %b", i, reg_we, i == WE_LAT);
            end
        end
        n_chk++;
        if (reg_addr !== 7'h05 || reg_wdata !== 8'h3C) begin
            n_fail++;
            $display("FAIL we_tim bus: got %h/%h want 05/3c", reg_addr, reg_wdata);
        end
        spi_ss = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if (fe_cnt !== fe0) begin
            n_fail++;
            $display("FAIL we_tim err: got %0d want 0", fe_cnt - fe0);
        end
    endtask

`ifdef SPI_FRAME_CRC_EN
    task automatic test_bad_crc();
        fb = '{8'h85, 8'h3C};
        fb.push_back(crc8(crc8(8'h00, 8'h85), 8'h3C) ^ 8'h01);
        run_frame("bad_crc");
    endtask
`endif

    task automatic test_read();
        fb = '{8'h12};
        fb.push_back(CRC_ON ? crc8(8'h00, 8'h12) : 8'h00);
        rd_val = 8'hA7;
        run_frame("read");
    endtask

    task automatic test_abort();
        fb = '{8'h85};
        run_frame("abort");
    endtask

    task automatic test_overrun();
        fb = '{8'h85, 8'h3C};
        if (CRC_ON) fb.push_back(crc8(crc8(8'h00, 8'h85), 8'h3C));
        fb.push_back(8'h77);
        run_frame("overrun");
    endtask

    task automatic test_ss_wins();
        int we0, fe0;
        we0 = we_cnt; fe0 = fe_cnt;
        start_frame("ss_wins");
        send_byte(8'h85);
        @(negedge clk);
        rx_byte = 8'h3C;
        rx_strobe = 1'b1;
        spi_ss = 1'b1;
        @(negedge clk);
        rx_strobe = 1'b0;
        repeat (3) @(negedge clk);
        account_err(1);
        n_chk++;
        if (we_cnt !== we0 || fe_cnt - fe0 !== 1) begin
            n_fail++;
            $display("FAIL ss_wins: got we %0d err %0d want 0/1", we_cnt - we0, fe_cnt - fe0);
        end
        check_errcnt("ss_wins");
    endtask

    task automatic test_random();
        bit wr;
        int need, n;
        logic [7:0] cor;
        for (int r = 0; r < 40; r++) begin
            wr = 1'($urandom_range(0, 1));
            need = (wr && CRC_ON) ? 3 : 2;
            n = $urandom_range(0, need + 1);
            cor = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            rd_val = 8'($urandom);
            build(wr, n, cor);
            run_frame("random");
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i <= CNTMAX; i++) begin
            fb = '{8'h85};
            run_frame("saturate");
        end
        n_chk++;
        if (err_cnt !== '1) begin
            n_fail++;
            $display("FAIL saturate: got %0d want %0d", err_cnt, CNTMAX);
        end
    endtask

    task automatic test_reset_mid();
        int we0, fe0;
        start_frame("rst_mid");
        send_byte(8'h85);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        we0 = we_cnt; fe0 = fe_cnt;
        exp_errcnt = 0;
        exp_sticky = 1'b0;
        n_chk++;
        if (tx_byte !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_mid tx: got %h want 00", tx_byte);
        end
        check_errcnt("rst_mid");
        spi_ss = 1'b1;
        repeat (4) @(negedge clk);
        n_chk++;
        if (we_cnt !== we0 || fe_cnt !== fe0) begin
            n_fail++;
            $display("FAIL rst_mid strobes: got we %0d err %0d", we_cnt - we0, fe_cnt - fe0);
        end
        fb = '{8'h85, 8'h11};
        if (CRC_ON) fb.push_back(crc8(crc8(8'h00, 8'h85), 8'h11));
        run_frame("post_rst");
    endtask

    initial begin
        rst = 1'b1;
        spi_ss = 1'b1;
        rx_byte = 8'h00;
        rx_strobe = 1'b0;
        crc_in = 8'h00;
        tx_strobe = 1'b0;
        reg_rdata = 8'h00;
        rd_val = 8'h00;
        crc_run = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_write();
        test_we_timing();
`ifdef SPI_FRAME_CRC_EN
        test_bad_crc();
`endif
        test_read();
        test_abort();
        test_overrun();
        test_ss_wins();
        test_random();
        test_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
